// File: rtl/pin_bank_checker_if.sv
// Control/result bundle between the test controller (master) and the pin bank checker (slave).
interface pin_bank_checker_if #(
    parameter int WIDTH = 40
);
    localparam int FW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);

    logic             start;
    logic [WIDTH-1:0] pins_in;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic             res_pass;
    logic             res_unstable;
    logic [FW-1:0]    res_fail_cnt;
    logic [IW-1:0]    res_first_idx;

    modport master (
        output start, pins_in, res_ready,
        input  busy, res_valid, res_pass, res_unstable, res_fail_cnt, res_first_idx
    );

    modport slave (
        input  start, pins_in, res_ready,
        output busy, res_valid, res_pass, res_unstable, res_fail_cnt, res_first_idx
    );
endinterface

// File: rtl/pin_bank_checker.sv
// Synchronises a pin bank, waits for it to settle, scans it bit-serially against EXPECT
// and hands one result record to the controller over valid/ready.
module pin_bank_checker #(
    parameter int               WIDTH    = 40,
    parameter logic [WIDTH-1:0] EXPECT   = {WIDTH{1'b1}},
    parameter int               STABLE_N = 16,
    parameter int               MAX_WAIT = 1024
) (
    input logic clk,
    input logic rst,
    pin_bank_checker_if.slave bus
);
    localparam int FW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);
    localparam int SW = $clog2(STABLE_N);
    localparam int WW = $clog2(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, SETTLE, SCAN, REPORT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sync1, sync2, prev, snap;
    logic [SW-1:0]    stab_cnt;
    logic [WW-1:0]    wait_cnt;
    logic [IW-1:0]    idx, first_idx;
    logic [FW-1:0]    fail_cnt, fail_nxt;
    logic             first_seen;
    logic             pass_r, unstable_r;
    logic [FW-1:0]    fail_r;
    logic [IW-1:0]    first_r;
    logic             changed, settled, timeout, mismatch, last;

    assign changed  = (sync2 != prev);
    assign settled  = !changed && (stab_cnt == SW'(STABLE_N - 1));
    assign timeout  = (wait_cnt == WW'(MAX_WAIT - 1));
    assign mismatch = (snap[idx] != EXPECT[idx]);
    assign last     = (idx == IW'(WIDTH - 1));
    assign fail_nxt = fail_cnt + FW'(mismatch);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SETTLE;
            // Settling wins over the timeout when both land on the same cycle.
            SETTLE:  if (settled) state_nxt = SCAN;
                     else if (timeout) state_nxt = REPORT;
            SCAN:    if (last) state_nxt = REPORT;
            REPORT:  if (bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= '0;
            sync2      <= '0;
            prev       <= '0;
            snap       <= '0;
            stab_cnt   <= '0;
            wait_cnt   <= '0;
            idx        <= '0;
            first_idx  <= '0;
            fail_cnt   <= '0;
            first_seen <= 1'b0;
            pass_r     <= 1'b0;
            unstable_r <= 1'b0;
            fail_r     <= '0;
            first_r    <= '0;
        end else begin
            sync1 <= bus.pins_in;
            sync2 <= sync1;
            prev  <= sync2;
            case (state)
                IDLE: if (bus.start) begin
                    stab_cnt   <= '0;
                    wait_cnt   <= '0;
                    idx        <= '0;
                    first_idx  <= '0;
                    fail_cnt   <= '0;
                    first_seen <= 1'b0;
                end
                SETTLE: begin
                    stab_cnt <= changed ? '0 : stab_cnt + 1'b1;
                    wait_cnt <= wait_cnt + 1'b1;
                    if (settled) begin
                        snap <= sync2;
                    end else if (timeout) begin
                        unstable_r <= 1'b1;
                        pass_r     <= 1'b0;
                        fail_r     <= '0;
                        first_r    <= '0;
                    end
                end
                SCAN: begin
                    idx <= idx + 1'b1;
                    if (mismatch) begin
                        fail_cnt <= fail_nxt;
                        if (!first_seen) begin
                            first_idx  <= idx;
                            first_seen <= 1'b1;
                        end
                    end
                    // Publish using this cycle's bit so the last index is counted.
                    if (last) begin
                        pass_r     <= (fail_nxt == '0);
                        fail_r     <= fail_nxt;
                        first_r    <= (mismatch && !first_seen) ? idx : first_idx;
                        unstable_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy          = (state != IDLE);
    assign bus.res_valid     = (state == REPORT);
    assign bus.res_pass      = pass_r;
    assign bus.res_unstable  = unstable_r;
    assign bus.res_fail_cnt  = fail_r;
    assign bus.res_first_idx = first_r;
endmodule

// File: tb/tb_pin_bank_checker.sv
// Randomised self-checking bench for pin_bank_checker against a bit-count reference model.
module tb_pin_bank_checker;
    localparam int W = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [W-1:0] pins_base = '1;
    logic         tog = 1'b0;
    logic         tog_en = 1'b0;
    int           tog_cnt = 0;

    pin_bank_checker_if #(.WIDTH(W)) bus ();
    assign bus.pins_in = pins_base ^ {{(W-1){1'b0}}, tog};

    pin_bank_checker #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tog_en) begin
            tog_cnt = tog_cnt + 1;
            if (tog_cnt % 8 == 0) tog = ~tog;
        end
    end

    // Expected record for a stable bank compared against all ones.
    function automatic void model(input logic [W-1:0] p, output logic pass,
                                  output int fails, output int first);
        fails = 0;
        first = -1;
        for (int i = 0; i < W; i++) begin
            if (p[i] !== 1'b1) begin
                fails++;
                if (first < 0) first = i;
            end
        end
        if (first < 0) first = 0;
        pass = (fails == 0);
    endfunction

    // Pulse start and wait for res_valid; lat counts cycles including the start cycle.
    task automatic run_wait(input int bound, output int lat, output bit to);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.res_valid && lat < bound) begin
            @(negedge clk);
            lat++;
        end
        to = !bus.res_valid;
    endtask

    task automatic settle_pins(input logic [W-1:0] p);
        @(negedge clk);
        pins_base = p;
        repeat (4) @(negedge clk);
    endtask

    task automatic consume();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.res_valid, bus.res_pass, bus.res_unstable} !== 4'b0 ||
            bus.res_fail_cnt !== '0 || bus.res_first_idx !== '0) begin
            n_errors++;
            $display("FAIL reset: busy=%b valid=%b pass=%b unst=%b fail=%0d first=%0d, want all 0",
                     bus.busy, bus.res_valid, bus.res_pass, bus.res_unstable,
                     bus.res_fail_cnt, bus.res_first_idx);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_pattern(input string name, input logic [W-1:0] p, input bit chk_lat);
        int lat; bit to; logic ep; int ef, efi;
        model(p, ep, ef, efi);
        settle_pins(p);
        run_wait(3000, lat, to);
        n_checks++;
        if (to) begin
            n_errors++;
            $display("FAIL %s timeout: no res_valid within %0d cycles", name, lat);
        end
        if (chk_lat) begin
            n_checks++;
            if (lat < 55 || lat > 59) begin
                n_errors++;
                $display("FAIL %s latency: got %0d, want 57 (+-2)", name, lat);
            end
        end
        n_checks++;
        if (bus.res_pass !== ep || bus.res_fail_cnt !== ef[5:0] ||
            bus.res_first_idx !== efi[5:0] || bus.res_unstable !== 1'b0) begin
            n_errors++;
            $display("FAIL %s record: pass=%b fail=%0d first=%0d unst=%b, want pass=%b fail=%0d first=%0d unst=0",
                     name, bus.res_pass, bus.res_fail_cnt, bus.res_first_idx, bus.res_unstable,
                     ep, ef, efi);
        end
        consume();
        n_checks++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s release: valid=%b busy=%b, want 0 0", name, bus.res_valid, bus.busy);
        end
    endtask

    task automatic test_patterns();
        logic [W-1:0] p;
        check_pattern("all_ones", '1, 1'b1);
        p = '1; p[7] = 1'b0; p[33] = 1'b0;
        check_pattern("bits_7_33", p, 1'b1);
        check_pattern("all_zeros", '0, 1'b1);
        p = '1; p[W-1] = 1'b0;
        check_pattern("top_bit", p, 1'b0);
    endtask

    task automatic test_random();
        logic [W-1:0] p;
        for (int k = 0; k < 8; k++) begin
            p = '1;
            if (k % 2 == 0) p = {$urandom, $urandom} & {W{1'b1}};
            else for (int j = 0; j < 3; j++) p[$urandom_range(W-1, 0)] = 1'b0;
            check_pattern($sformatf("random%0d", k), p, 1'b0);
        end
    endtask

    task automatic test_unstable();
        int lat; bit to;
        settle_pins('1);
        tog_cnt = 0;
        tog_en = 1'b1;
        run_wait(2000, lat, to);
        tog_en = 1'b0;
        n_checks++;
        if (to || lat < 1024 || lat > 1028) begin
            n_errors++;
            $display("FAIL unstable latency: got %0d (timeout=%b), want ~1025", lat, to);
        end
        n_checks++;
        if (bus.res_unstable !== 1'b1 || bus.res_pass !== 1'b0 ||
            bus.res_fail_cnt !== '0 || bus.res_first_idx !== '0) begin
            n_errors++;
            $display("FAIL unstable record: unst=%b pass=%b fail=%0d first=%0d, want 1 0 0 0",
                     bus.res_unstable, bus.res_pass, bus.res_fail_cnt, bus.res_first_idx);
        end
        consume();
        tog = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat; bit to; logic ep; int ef, efi; int bad;
        logic [W-1:0] p;
        p = '1; p[3] = 1'b0; p[20] = 1'b0; p[21] = 1'b0;
        model(p, ep, ef, efi);
        settle_pins(p);
        run_wait(3000, lat, to);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            bus.start = (c == 5);
            if (c == 8) pins_base = '0;
            @(negedge clk);
            if (bus.res_valid !== 1'b1 || bus.res_pass !== ep || bus.res_fail_cnt !== ef[5:0] ||
                bus.res_first_idx !== efi[5:0] || bus.res_unstable !== 1'b0) bad++;
        end
        bus.start = 1'b0;
        n_checks++;
        if (to || bad != 0) begin
            n_errors++;
            $display("FAIL backpressure hold: %0d bad cycles (timeout=%b), want 0", bad, to);
        end
        // start coincident with the handshake must not launch a new check
        bus.res_ready = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        bus.start = 1'b0;
        n_checks++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL backpressure release: valid=%b busy=%b, want 0 0", bus.res_valid, bus.busy);
        end
        n_checks++;
        if (bus.res_fail_cnt !== ef[5:0] || bus.res_first_idx !== efi[5:0]) begin
            n_errors++;
            $display("FAIL backpressure post-hold: fail=%0d first=%0d, want %0d %0d",
                     bus.res_fail_cnt, bus.res_first_idx, ef, efi);
        end
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL start_at_handshake: busy=%b, want 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [W-1:0] p;
        p = '1; p[2] = 1'b0; p[30] = 1'b0;
        settle_pins(p);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (36) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({bus.busy, bus.res_valid, bus.res_pass, bus.res_unstable} !== 4'b0 ||
            bus.res_fail_cnt !== '0 || bus.res_first_idx !== '0) begin
            n_errors++;
            $display("FAIL mid_scan_reset: busy=%b valid=%b pass=%b unst=%b fail=%0d first=%0d, want all 0",
                     bus.busy, bus.res_valid, bus.res_pass, bus.res_unstable,
                     bus.res_fail_cnt, bus.res_first_idx);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.res_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_scan_no_record: valid=%b, want 0", bus.res_valid);
        end
        check_pattern("after_reset", p, 1'b1);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.res_ready = 1'b0;
        test_reset();
        test_patterns();
        test_random();
        test_unstable();
        test_backpressure();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
